writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Writeback stage directly upstream of the 16x32 register file. Merges single-cycle ALU results
//  with load returns from data memory into the file's single write port (rf_addr_w/rf_data_w/rf_write_en).
//  Queues loads that collide with ALU writes and keeps a per-register pending-load scoreboard for hazard stall.
// PARAMETERS
//  LQ_DEPTH    4   load-return queue entries (power of 2, >=2)
//  LQ_AW       2   queue pointer width, log2(LQ_DEPTH)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  alu_valid    in   1   ALU result valid this cycle (no backpressure)
//  alu_rd       in   4   ALU destination register
//  alu_data     in   32  ALU result
//  ld_issue     in   1   load issued to memory this cycle
//  ld_issue_rd  in   4   destination of issued load
//  ld_valid     in   1   memory load return valid
//  ld_ready     out  1   stage can accept load return
//  ld_rd        in   4   load return destination
//  ld_data      in   32  load return data
//  rf_addr_w    out  4   register file write address
//  rf_data_w    out  32  register file write data
//  rf_write_en  out  1   register file write enable
//  busy_mask    out  16  bit r = load to Rr outstanding
//  lq_count     out  LQ_AW+1  queued load returns
//  byp_addr_a/b in   4   register file read addresses (mirrored)
//  rf_rd_a/b    in   32  register file read data
//  fwd_a/b      out  32  forwarded operand data
// BEHAVIOUR
//  - Reset (rst=1 at edge): rf_write_en=0, rf_addr_w=0, rf_data_w=0, busy_mask=0, queue emptied,
//    lq_count=0; ld_ready=0 while rst high. Reset mid-operation drops queued loads and clears scoreboard;
//    returns arriving after reset are accepted and written normally.
//  - Write outputs registered; rf_write_en is a 1-cycle pulse per write. ALU result sampled at edge N
//    drives the write in cycle N+1 (latency 1). ALU has absolute priority, never stalled.
//  - Load path: ld_ready = !full (registered count); accept on ld_valid&&ld_ready into FIFO.
//    No push when full even if a pop occurs same cycle. A cycle with alu_valid=0 and queue non-empty
//    pops head; write appears next cycle. Min load latency accept->rf_write_en = 2 cycles.
//  - Push and pop in same cycle legal; lq_count unchanged; pointers wrap modulo LQ_DEPTH.
//  - rd==0: ALU result dropped (no write pulse); load with rd 0 accepted/popped, no write pulse.
//  - Scoreboard: ld_issue with rd!=0 sets busy_mask[rd] at next edge. Popping a load to rd clears
//    busy_mask[rd] at the same edge rf_write_en rises. Set and clear of same bit in one cycle: set wins.
//  - Upstream hazard logic guarantees no second ld_issue or ALU write to a busy register; violation
//    is a protocol error flagged by a simulation-only assertion, RTL behaviour then undefined.
//  - No arithmetic on data; all 32 bits passed unchanged.
// CONFIGURATION
//  WB_BYPASS_EN defined: fwd_a = (rf_write_en && rf_addr_w==byp_addr_a && byp_addr_a!=0) ? rf_data_w
//    : rf_rd_a (same for b), combinational, covers the sync-write/async-read same-cycle hazard.
//  WB_BYPASS_EN undefined: fwd_a=rf_rd_a, fwd_b=rf_rd_b (pure pass-through); byp_addr_* unused.
// TESTING
//  1 Hold rst 2 cycles, release -> rf_write_en=0, busy_mask=0x0000, lq_count=0, ld_ready=1.
//  2 alu_valid, rd=3, data=0xDEADBEEF at edge N -> cycle N+1: rf_write_en=1, addr 3, data 0xDEADBEEF; N+2 en=0.
//  3 alu_valid rd=0 data=0xFFFFFFFF -> rf_write_en stays 0 for all following cycles.
//  4 ld_issue rd=5 -> busy_mask=0x0020; ld_valid rd=5 0x12345678 during 3 ALU cycles -> load written the
//    cycle after ALU stops, busy_mask=0x0000 in that cycle.
//  5 ALU valid continuously, 5 load returns offered -> lq_count=4, ld_ready=0, 5th held; ALU stops ->
//    4 writes in FIFO order, ld_ready returns 1 after first pop.
//  6 Write R7=0xA5A5A5A5, byp_addr_a=7, rf_rd_a=0 -> fwd_a=0xA5A5A5A5 with WB_BYPASS_EN, 0x00000000 without.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: merges ALU results and queued load returns onto the single register-file write port.
// Latency: ALU 1 cycle; load return 2 cycles minimum, longer while the ALU holds the port. WB_BYPASS_EN adds forwarding.
// Backpressure: ALU is never stalled; ld_ready drops while the load-return queue is full.

module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    // Generic circular FIFO; push is refused when full even if a pop happens in the same cycle.
    // Latency: pushed entry is visible at the head one cycle later.
    // Backpressure: full/empty derived from the registered count.

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module writeback_stage #(
    parameter int LQ_DEPTH = 4,
    parameter int LQ_AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [3:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             ld_issue,
    input  logic [3:0]       ld_issue_rd,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [3:0]       ld_rd,
    input  logic [31:0]      ld_data,
    output logic [3:0]       rf_addr_w,
    output logic [31:0]      rf_data_w,
    output logic             rf_write_en,
    output logic [15:0]      busy_mask,
    output logic [LQ_AW:0]   lq_count,
    input  logic [3:0]       byp_addr_a,
    input  logic [3:0]       byp_addr_b,
    input  logic [31:0]      rf_rd_a,
    input  logic [31:0]      rf_rd_b,
    output logic [31:0]      fwd_a,
    output logic [31:0]      fwd_b
);
    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } ld_ent_t;

    ld_ent_t     lq_head;
    ld_ent_t     lq_in;
    logic        lq_full;
    logic        lq_empty;
    logic        lq_pop;
    logic [15:0] busy_nxt;

    assign lq_in    = '{rd: ld_rd, data: ld_data};
    assign ld_ready = !rst && !lq_full;
    // The port is free for a load only when the ALU is idle this cycle.
    assign lq_pop   = !alu_valid && !lq_empty;

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .AW    (LQ_AW),
        .W     ($bits(ld_ent_t))
    ) u_lq (
        .clk      (clk),
        .rst      (rst),
        .push_vld (ld_valid && ld_ready),
        .push_dat (lq_in),
        .pop_vld  (lq_pop),
        .pop_dat  (lq_head),
        .count    (lq_count),
        .full     (lq_full),
        .empty    (lq_empty)
    );

    // Set is applied after clear so a same-cycle issue to the retiring register wins.
    always_comb begin
        busy_nxt = busy_mask;
        if (lq_pop && lq_head.rd != 4'd0) begin
            busy_nxt[lq_head.rd] = 1'b0;
        end
        if (ld_issue && ld_issue_rd != 4'd0) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en <= 1'b0;
            rf_addr_w   <= 4'd0;
            rf_data_w   <= 32'd0;
            busy_mask   <= 16'd0;
        end else begin
            rf_write_en <= 1'b0;
            busy_mask   <= busy_nxt;
            if (alu_valid) begin
                if (alu_rd != 4'd0) begin
                    rf_write_en <= 1'b1;
                    rf_addr_w   <= alu_rd;
                    rf_data_w   <= alu_data;
                end
            end else if (lq_pop && lq_head.rd != 4'd0) begin
                rf_write_en <= 1'b1;
                rf_addr_w   <= lq_head.rd;
                rf_data_w   <= lq_head.data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Register file writes land at the edge but reads are asynchronous: forward the in-flight write.
    assign fwd_a = (rf_write_en && rf_addr_w == byp_addr_a && byp_addr_a != 4'd0) ? rf_data_w : rf_rd_a;
    assign fwd_b = (rf_write_en && rf_addr_w == byp_addr_b && byp_addr_b != 4'd0) ? rf_data_w : rf_rd_b;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_addr_a, byp_addr_b};
    assign fwd_a      = rf_rd_a;
    assign fwd_b      = rf_rd_b;
`endif

`ifndef SYNTHESIS
    a_no_issue_to_busy: assert property (@(posedge clk) disable iff (rst)
        !(ld_issue && ld_issue_rd != 4'd0 && busy_mask[ld_issue_rd]));
    a_no_alu_to_busy: assert property (@(posedge clk) disable iff (rst)
        !(alu_valid && alu_rd != 4'd0 && busy_mask[alu_rd]));
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a write-port scoreboard for ALU and load results.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic [3:0]  rf_addr_w;
    logic [31:0] rf_data_w;
    logic        rf_write_en;
    logic [15:0] busy_mask;
    logic [2:0]  lq_count;
    logic [3:0]  byp_addr_a;
    logic [3:0]  byp_addr_b;
    logic [31:0] rf_rd_a;
    logic [31:0] rf_rd_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    writeback_stage #(.LQ_DEPTH(4), .LQ_AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .rf_addr_w   (rf_addr_w),
        .rf_data_w   (rf_data_w),
        .rf_write_en (rf_write_en),
        .busy_mask   (busy_mask),
        .lq_count    (lq_count),
        .byp_addr_a  (byp_addr_a),
        .byp_addr_b  (byp_addr_b),
        .rf_rd_a     (rf_rd_a),
        .rf_rd_b     (rf_rd_b),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t alu_exp[$];
    exp_t ld_exp[$];
    exp_t mon_e;
    logic prev_alu = 1'b0;
    logic mon_en   = 1'b0;
    int   n_chk    = 0;
    int   n_bad    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected writes are queued at the edge where the DUT samples the stimulus.
    always @(posedge clk) begin
        prev_alu <= !rst && alu_valid && alu_rd != 4'd0;
        if (rst) begin
            ld_exp.delete();
        end else begin
            if (alu_valid && alu_rd != 4'd0) alu_exp.push_back('{rd: alu_rd, data: alu_data});
            if (ld_valid && ld_ready && ld_rd != 4'd0) ld_exp.push_back('{rd: ld_rd, data: ld_data});
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_alu) begin
                chk("alu_wen", 32'(rf_write_en), 32'd1);
                if (alu_exp.size() > 0) begin
                    mon_e = alu_exp.pop_front();
                    chk("alu_addr", 32'(rf_addr_w), 32'(mon_e.rd));
                    chk("alu_data", rf_data_w, mon_e.data);
                end
            end else if (rf_write_en === 1'b1) begin
                chk("ld_pending", 32'(ld_exp.size() > 0), 32'd1);
                if (ld_exp.size() > 0) begin
                    mon_e = ld_exp.pop_front();
                    chk("ld_addr", 32'(rf_addr_w), 32'(mon_e.rd));
                    chk("ld_data", rf_data_w, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic rdy;
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        byp_addr_a = '0; byp_addr_b = '0; rf_rd_a = '0; rf_rd_b = '0;

        // Reset held for two cycles
        step();
        step();
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_wen", 32'(rf_write_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ld_ready", 32'(ld_ready), 32'd1);
        chk("rel_busy", 32'(busy_mask), 32'h0);
        chk("rel_lq_count", 32'(lq_count), 32'd0);
        chk("rel_addr", 32'(rf_addr_w), 32'd0);
        chk("rel_data", rf_data_w, 32'd0);
        mon_en = 1'b1;

        // Single ALU write, latency 1, one-cycle pulse
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("t2_wen", 32'(rf_write_en), 32'd1);
        chk("t2_addr", 32'(rf_addr_w), 32'd3);
        chk("t2_data", rf_data_w, 32'hDEADBEEF);
        step();
        chk("t2_wen_off", 32'(rf_write_en), 32'd0);

        // ALU write to R0 is dropped
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFFFFFF;
        step();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_r0_wen", 32'(rf_write_en), 32'd0);
            step();
        end

        // Load to R5 collides with three ALU cycles
        ld_issue = 1'b1; ld_issue_rd = 4'd5;
        step();
        ld_issue = 1'b0;
        chk("t4_busy_set", 32'(busy_mask), 32'h0020);
        ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 4'(i + 1); alu_data = $urandom;
            step();
            ld_valid = 1'b0;
        end
        chk("t4_lq_held", 32'(lq_count), 32'd1);
        chk("t4_busy_hold", 32'(busy_mask), 32'h0020);
        alu_valid = 1'b0;
        step();
        chk("t4_wen", 32'(rf_write_en), 32'd1);
        chk("t4_addr", 32'(rf_addr_w), 32'd5);
        chk("t4_data", rf_data_w, 32'h12345678);
        chk("t4_busy_clr", 32'(busy_mask), 32'h0000);
        step();

        // Queue fills under continuous ALU traffic; fifth return held
        k = 0;
        ld_valid = 1'b1; ld_rd = 4'd9; ld_data = 32'h10000000;
        for (int c = 0; c < 7; c++) begin
            alu_valid = 1'b1; alu_rd = 4'(1 + c); alu_data = $urandom;
            rdy = ld_ready;
            step();
            if (rdy && k < 4) begin
                k++;
                ld_rd = 4'(9 + k); ld_data = 32'h10000000 + 32'(k);
            end
        end
        chk("t5_accepted", 32'(k), 32'd4);
        chk("t5_full_cnt", 32'(lq_count), 32'd4);
        chk("t5_full_rdy", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        step();
        chk("t5_first_addr", 32'(rf_addr_w), 32'd9);
        chk("t5_first_data", rf_data_w, 32'h10000000);
        chk("t5_rdy_back", 32'(ld_ready), 32'd1);
        chk("t5_cnt_pop", 32'(lq_count), 32'd3);
        step();
        ld_valid = 1'b0;
        chk("t5_cnt_pushpop", 32'(lq_count), 32'd3);
        for (int i = 0; i < 5; i++) step();
        chk("t5_drained", 32'(lq_count), 32'd0);

        // Same-cycle bypass of R7 write
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'hA5A5A5A5;
        byp_addr_a = 4'd7; rf_rd_a = 32'h0;
        byp_addr_b = 4'd7; rf_rd_b = 32'h11111111;
        step();
        alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("t6_fwd_a", fwd_a, 32'hA5A5A5A5);
        chk("t6_fwd_b", fwd_b, 32'hA5A5A5A5);
`else
        chk("t6_fwd_a", fwd_a, 32'h00000000);
        chk("t6_fwd_b", fwd_b, 32'h11111111);
`endif
        step();
        chk("t6_fwd_a_idle", fwd_a, 32'h00000000);
        byp_addr_a = '0; byp_addr_b = '0; rf_rd_b = '0;

        // Reset mid-operation drops queued loads and pending scoreboard bits
        ld_issue = 1'b1; ld_issue_rd = 4'd6;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'h55AA55AA;
        ld_valid = 1'b1; ld_rd = 4'd2; ld_data = 32'h0BAD0001;
        step();
        ld_issue = 1'b0; alu_rd = 4'd2; ld_rd = 4'd4; ld_data = 32'h0BAD0002;
        step();
        ld_valid = 1'b0;
        chk("t7_busy", 32'(busy_mask), 32'h0040);
        chk("t7_cnt", 32'(lq_count), 32'd2);
        rst = 1'b1;
        step();
        alu_valid = 1'b0;
        chk("t7_rst_cnt", 32'(lq_count), 32'd0);
        chk("t7_rst_busy", 32'(busy_mask), 32'h0);
        chk("t7_rst_rdy", 32'(ld_ready), 32'd0);
        rst = 1'b0;
        ld_valid = 1'b1; ld_rd = 4'd0; ld_data = 32'hFFFF0000;
        step();
        ld_rd = 4'd14; ld_data = 32'hC0FFEE00;
        step();
        ld_valid = 1'b0;
        chk("t7_r0_load_wen", 32'(rf_write_en), 32'd0);
        chk("t7_cnt_one", 32'(lq_count), 32'd1);
        step();
        chk("t7_post_wen", 32'(rf_write_en), 32'd1);
        chk("t7_post_addr", 32'(rf_addr_w), 32'd14);
        chk("t7_post_data", rf_data_w, 32'hC0FFEE00);
        step();
        step();

        chk("end_alu_q", 32'(alu_exp.size()), 32'd0);
        chk("end_ld_q", 32'(ld_exp.size()), 32'd0);
        chk("end_lq_count", 32'(lq_count), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
